// File: rtl/fir_pkg.sv
// Shared constants, state type and symbol-to-level map for the FIR feed sequencer.
package fir_pkg;

    localparam int FIR_UPS      = 4;
    localparam int FIR_NTAPS    = 81;
    localparam int FIR_PIPE_LAT = 11;
    localparam int FIR_CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // 2*sym-7 in 4-bit two's complement: {sym,1} - 8 is just {sym,1} with the MSB flipped.
    function automatic logic signed [3:0] sym_to_level(input logic [2:0] sym);
        return $signed({~sym[2], sym[1:0], 1'b1});
    endfunction

endpackage

// File: rtl/fir_valid_dly.sv
// DEPTH-stage 1-bit delay line aligning burst activity with the FIR output.
module fir_valid_dly #(
    parameter int DEPTH = 11
) (
    input  logic clk,
    input  logic nrst,
    input  logic i_din,
    output logic o_dout,
    output logic o_any
);

    logic [DEPTH-1:0] r_sr;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sr <= '0;
        end else begin
            r_sr[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_dout = r_sr[DEPTH-1];
    assign o_any  = |r_sr;

endmodule

// File: rtl/fir_feed_ctrl.sv
// Symbol sequencer for the pulse-shaping FIR: level map, zero-stuffing, drain and
// shape-valid tracking.
module fir_feed_ctrl
    import fir_pkg::*;
#(
    parameter int UPS      = FIR_UPS,
    parameter int NTAPS    = FIR_NTAPS,
    parameter int PIPE_LAT = FIR_PIPE_LAT,
    parameter int CNT_W    = FIR_CNT_W
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_sym_valid,
    input  logic [2:0]          i_sym,
    output logic                o_sym_ready,
    output logic signed [3:0]   o_fir_data,
    output logic                o_shape_valid,
    output logic                o_busy,
    output logic                o_underrun,
    output logic [CNT_W-1:0]    o_underrun_cnt,
    output state_t              o_state
);

    localparam int PH_W = (UPS > 1) ? $clog2(UPS) : 1;
    localparam int DR_W = $clog2(NTAPS);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(UPS - 1);
    localparam logic [DR_W-1:0]  DR_LAST = DR_W'(NTAPS - 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              r_state;
    logic [PH_W-1:0]     r_phase;
    logic                r_stop_pend;
    logic [DR_W-1:0]     r_drain_cnt;
    logic signed [3:0]   r_fir_data;
    logic                r_act_q;
    logic                r_underrun;
    logic [CNT_W-1:0]    r_underrun_cnt;
    logic                w_dly_any;
    logic                w_shape_valid;
    logic                w_handshake;

    // Handshake: a symbol transfers on a clk edge where i_sym_valid && o_sym_ready;
    // ready depends only on state/phase, so valid may wait on it without a loop.
    assign o_sym_ready = (r_state == RUN) && (r_phase == '0);
    assign w_handshake = i_sym_valid && o_sym_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state        <= IDLE;
            r_phase        <= '0;
            r_stop_pend    <= 1'b0;
            r_drain_cnt    <= '0;
            r_fir_data     <= 4'sd0;
            r_act_q        <= 1'b0;
            r_underrun     <= 1'b0;
            r_underrun_cnt <= '0;
        end else begin
            r_underrun <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_fir_data <= 4'sd0;
                    r_act_q    <= 1'b0;
                    if (i_start && !o_busy) begin
                        r_state        <= RUN;
                        r_phase        <= '0;
                        r_underrun_cnt <= '0;
                        r_stop_pend    <= i_stop;
                    end
                end
                RUN: begin
                    r_act_q <= 1'b1;
                    if (r_phase == '0) begin
                        if (w_handshake) begin
                            r_fir_data <= sym_to_level(i_sym);
                        end else begin
                            r_fir_data <= 4'sd0;
                            r_underrun <= 1'b1;
                            if (r_underrun_cnt != CNT_MAX) begin
                                r_underrun_cnt <= r_underrun_cnt + 1'b1;
                            end
                        end
                    end else begin
                        r_fir_data <= 4'sd0;
                    end
                    if (i_stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (r_phase == PH_LAST) begin
                        r_phase <= '0;
                        if (r_stop_pend || i_stop) begin
                            r_state     <= DRAIN;
                            r_drain_cnt <= '0;
                            r_stop_pend <= 1'b0;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                DRAIN: begin
                    r_fir_data <= 4'sd0;
                    r_act_q    <= 1'b1;
                    if (r_drain_cnt == DR_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    fir_valid_dly #(
        .DEPTH (PIPE_LAT)
    ) u_valid_dly (
        .clk    (clk),
        .nrst   (nrst),
        .i_din  (r_act_q),
        .o_dout (w_shape_valid),
        .o_any  (w_dly_any)
    );

    assign o_fir_data     = r_fir_data;
    assign o_shape_valid  = w_shape_valid;
    assign o_busy         = (r_state != IDLE) || w_dly_any || r_act_q;
    assign o_underrun     = r_underrun;
    assign o_underrun_cnt = r_underrun_cnt;
    assign o_state        = r_state;

endmodule

// File: tb/tb_fir_feed_ctrl.sv
// Directed bench for fir_feed_ctrl: vector table for the first burst, hand sequences for
// drain length, shape/busy tail, underruns, start+stop together and async reset.
module tb_fir_feed_ctrl;
    import fir_pkg::*;

    logic              clk;
    logic              nrst;
    logic              i_start;
    logic              i_stop;
    logic              i_sym_valid;
    logic [2:0]        i_sym;
    logic              o_sym_ready;
    logic signed [3:0] o_fir_data;
    logic              o_shape_valid;
    logic              o_busy;
    logic              o_underrun;
    logic [15:0]       o_underrun_cnt;
    state_t            o_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic   start;
        logic   stop;
        logic   sv;
        logic [2:0] sym;
        logic   ready;
        int     fir;
        logic   busy;
        logic   shape;
        state_t st;
    } vec_t;

    vec_t tbl[14];

    fir_feed_ctrl dut (
        .clk            (clk),
        .nrst           (nrst),
        .i_start        (i_start),
        .i_stop         (i_stop),
        .i_sym_valid    (i_sym_valid),
        .i_sym          (i_sym),
        .o_sym_ready    (o_sym_ready),
        .o_fir_data     (o_fir_data),
        .o_shape_valid  (o_shape_valid),
        .o_busy         (o_busy),
        .o_underrun     (o_underrun),
        .o_underrun_cnt (o_underrun_cnt),
        .o_state        (o_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (o_busy && k < bound) begin
            step();
            k++;
        end
        check("idle_reached", o_busy, 0);
    endtask

    // scoreboard: every accepted symbol must reappear as the next nonzero sample
    always @(negedge clk) begin
        if (!nrst) begin
            exp_q.delete();
        end else begin
            if (o_fir_data != 4'sd0) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_sample", o_fir_data, 0);
                end else begin
                    check("sb_level", o_fir_data, $signed(exp_q.pop_front()));
                end
            end
            if (i_sym_valid && o_sym_ready) begin
                exp_q.push_back(4'(2 * int'(i_sym) - 7));
            end
        end
    end

    initial begin
        int n;
        logic prev_shape;

        // start stop sv sym | ready fir busy shape state
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0,  0, 1'b0, 1'b0, IDLE};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 3'd7, 1'b1,  0, 1'b1, 1'b0, RUN};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0,  7, 1'b1, 1'b0, RUN};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0,  0, 1'b1, 1'b0, RUN};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0,  0, 1'b1, 1'b0, RUN};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b1,  0, 1'b1, 1'b0, RUN};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b0, -7, 1'b1, 1'b0, RUN};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b0,  0, 1'b1, 1'b0, RUN};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b0,  0, 1'b1, 1'b0, RUN};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b1,  0, 1'b1, 1'b0, RUN};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 3'd3, 1'b0, -1, 1'b1, 1'b0, RUN};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b0,  0, 1'b1, 1'b0, RUN};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b0,  0, 1'b1, 1'b0, RUN};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b0,  0, 1'b1, 1'b1, DRAIN};

        nrst = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_sym_valid = 1'b0; i_sym = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fir", o_fir_data, 0);
        check("rst_ready", o_sym_ready, 0);
        check("rst_busy", o_busy, 0);
        check("rst_shape", o_shape_valid, 0);
        check("rst_underrun", o_underrun, 0);
        check("rst_cnt", o_underrun_cnt, 0);
        check("rst_state", o_state, IDLE);
        nrst = 1'b1;
        step();

        // first burst: symbols 7,0,3, stop in phase 1, shape rises 11 cycles after first sample
        for (int i = 0; i < 14; i++) begin
            i_start = tbl[i].start; i_stop = tbl[i].stop;
            i_sym_valid = tbl[i].sv; i_sym = tbl[i].sym;
            #1;
            check($sformatf("row%0d_ready", i), o_sym_ready, tbl[i].ready);
            check($sformatf("row%0d_fir", i), o_fir_data, tbl[i].fir);
            check($sformatf("row%0d_busy", i), o_busy, tbl[i].busy);
            check($sformatf("row%0d_shape", i), o_shape_valid, tbl[i].shape);
            check($sformatf("row%0d_state", i), o_state, tbl[i].st);
            step();
        end
        i_start = 1'b0; i_stop = 1'b0;

        // drain length, with a start/stop pulse that must be ignored
        n = 1;
        while (o_state == DRAIN && n < 200) begin
            check("drain_fir", o_fir_data, 0);
            check("drain_ready", o_sym_ready, 0);
            if (n == 10) begin i_start = 1'b1; i_stop = 1'b1; end
            step();
            i_start = 1'b0; i_stop = 1'b0;
            n++;
        end
        check("drain_len", n, 80);
        check("tail_state", o_state, IDLE);
        check("tail_busy", o_busy, 1);
        check("tail_shape", o_shape_valid, 1);

        // pipe tail: busy and shape fall together 12 cycles after the last drain sample appears
        n = 0;
        prev_shape = 1'b0;
        while (o_busy && n < 50) begin
            check("tail_idle_state", o_state, IDLE);
            if (n == 2) i_start = 1'b1;
            prev_shape = o_shape_valid;
            step();
            i_start = 1'b0;
            n++;
        end
        check("tail_len", n, 12);
        check("tail_last_shape", prev_shape, 1);
        check("tail_shape_low", o_shape_valid, 0);
        check("tail_after_state", o_state, IDLE);

        // underruns: three empty symbol periods
        i_sym_valid = 1'b0;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 11) i_stop = 1'b1;
            check($sformatf("ur%0d_pulse", k), o_underrun, (k % 4) == 1);
            check($sformatf("ur%0d_cnt", k), o_underrun_cnt, (k + 3) / 4);
            check($sformatf("ur%0d_fir", k), o_fir_data, 0);
            check($sformatf("ur%0d_ready", k), o_sym_ready, (k % 4) == 0);
            step();
            i_stop = 1'b0;
        end
        check("ur_drain", o_state, DRAIN);
        wait_idle(200);
        check("ur_cnt_held", o_underrun_cnt, 3);

        // start and stop together: one symbol (5 -> 3) then drain; count cleared
        i_start = 1'b1; i_stop = 1'b1; i_sym_valid = 1'b1; i_sym = 3'd5;
        step();
        i_start = 1'b0; i_stop = 1'b0;
        check("ss_state", o_state, RUN);
        check("ss_cnt_clear", o_underrun_cnt, 0);
        check("ss_ready", o_sym_ready, 1);
        step();
        i_sym_valid = 1'b0;
        check("ss_fir0", o_fir_data, 3);
        step();
        check("ss_fir1", o_fir_data, 0);
        step();
        check("ss_fir2", o_fir_data, 0);
        check("ss_state3", o_state, RUN);
        step();
        check("ss_fir3", o_fir_data, 0);
        check("ss_drain", o_state, DRAIN);
        check("ss_no_underrun", o_underrun_cnt, 0);
        wait_idle(200);

        // asynchronous reset mid-run
        i_start = 1'b1; i_sym_valid = 1'b1; i_sym = 3'd7;
        step();
        i_start = 1'b0;
        step();
        i_sym_valid = 1'b0;
        check("pre_rst_fir", o_fir_data, 7);
        check("pre_rst_busy", o_busy, 1);
        nrst = 1'b0;
        #1;
        check("arst_fir", o_fir_data, 0);
        check("arst_busy", o_busy, 0);
        check("arst_state", o_state, IDLE);
        check("arst_ready", o_sym_ready, 0);
        check("arst_shape", o_shape_valid, 0);
        step();
        nrst = 1'b1;
        step();
        check("post_rst_busy", o_busy, 0);
        check("post_rst_state", o_state, IDLE);
        check("post_rst_shape", o_shape_valid, 0);

        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_feed_ctrl.md
Name: fir_feed_ctrl

Overview:
- Sequencer in front of the pipelined 81-tap raised-cosine pulse-shaping FIR.
- Accepts 8-PAM symbol indices over a valid/ready handshake and maps each to a signed level (-7..7).
- Produces the x4 zero-stuffed sample stream that drives the FIR data input.
- Tracks FIR pipeline latency to flag valid output samples, and drains the filter with zeros at end of burst.

Parameters:
- UPS, 4: upsampling factor; samples per symbol period.
- NTAPS, 81: FIR tap count; the drain phase feeds NTAPS-1 zero samples.
- PIPE_LAT, 11: cycles from fir_data presented to the corresponding shape output.
- CNT_W, 16: underrun counter width.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a burst; honoured only when busy=0
- stop  in  1  single-cycle pulse; ends burst after the current symbol period
- sym_valid  in  1  symbol available
- sym  in  3  symbol index 0..7
- sym_ready  out  1  symbol accepted when sym_valid&sym_ready at clk edge
- fir_data  out  4  signed sample to FIR data input (registered)
- shape_valid  out  1  FIR shape output is part of an active burst
- busy  out  1  burst running, draining, or samples still in FIR pipe
- underrun  out  1  one-cycle pulse: symbol slot passed with no symbol
- underrun_cnt  out  CNT_W  saturating count of underruns in current burst

Behaviour:
- Reset: nrst asserted (asynchronous) clears everything immediately, mid-operation included.
  - Outputs: fir_data=0, sym_ready=0, shape_valid=0, busy=0, underrun=0, underrun_cnt=0.
  - Internal: state=IDLE, phase=0, stop_pend=0, valid pipe cleared.
- State machine: IDLE, RUN, DRAIN. phase counts 0..UPS-1 and wraps to 0.
- IDLE:
  - fir_data=0, sym_ready=0.
  - start with busy=0: go to RUN, phase=0, underrun_cnt=0, stop_pend=0.
  - start with busy=1: ignored. stop in IDLE: ignored.
- RUN:
  - sym_ready is combinational: 1 iff state=RUN and phase=0. Asserted even when stop_pend=1, so the current period still takes a symbol.
  - At the phase-0 edge with handshake: fir_data <= 2*sym-7 (sym 0 -> -7, sym 7 -> +7).
  - At the phase-0 edge with no handshake: fir_data <= 0, underrun pulses the next cycle, and underrun_cnt increments, saturating at 2^CNT_W-1.
  - Phases 1..UPS-1: fir_data <= 0.
  - stop: sets stop_pend. At the edge ending phase UPS-1 with stop_pend (or stop) set, go to DRAIN with phase=0.
  - start while in RUN: ignored.
- DRAIN:
  - fir_data=0 for exactly NTAPS-1 cycles (80 by default), counted by a drain counter, then go to IDLE.
  - sym_ready=0. start and stop ignored.
- shape_valid:
  - act_q is set with each fir_data register update: 1 for samples written in RUN or DRAIN, else 0.
  - shape_valid = act_q delayed by PIPE_LAT cycles through a shift register; it is high exactly while shape reflects burst samples.
- busy = (state != IDLE) OR (any bit of the act delay line set) OR act_q.
- Simultaneous start and stop in IDLE: start is honoured and stop latched, so the burst runs one symbol period, then drains.
- Width rules: level computed as 4-bit signed. No arithmetic beyond the index map and counters.

Decomposition:
- Shared package fir_pkg:
  - constants for UPS, NTAPS, PIPE_LAT
  - state enum type (IDLE/RUN/DRAIN)
  - function for 3-bit index to 4-bit signed level map
- One natural sub-module: fir_valid_dly, a parameterised PIPE_LAT-deep 1-bit shift register with async reset, used for shape_valid alignment.

Test Plan:
- Reset, then start; hold sym_valid=1 with sym=7,0,3 -> fir_data sequence 7,0,0,0,-7,0,0,0,-1,0,0,0; sym_ready high only in phase-0 cycles.
- Start, first fir_data cycle at T -> shape_valid rises at T+11. Stop, then last drain sample at cycle D -> shape_valid falls after D+11 and busy deasserts the same cycle.
- Start with sym_valid=0 for 3 symbol periods -> three underrun pulses 4 cycles apart, underrun_cnt=3, fir_data all 0. Next start clears the count to 0.
- Stop pulse in phase 1 -> remaining phases 2,3 complete, then exactly 80 DRAIN cycles with fir_data=0, then IDLE. A start during DRAIN or while busy=1 is ignored.
- Start and stop in the same IDLE cycle with sym=5 -> one symbol (fir_data=3,0,0,0), then DRAIN.
- Assert nrst mid-RUN -> all outputs 0 immediately (asynchronous). After release, state is IDLE and busy=0.
